// File: rtl/tagged_arb_queue_pkg.sv
// Shared types and sizing constants for the tagged arbiter output queue.
package tagged_arb_pkg;

  localparam int DEPTH       = 4;
  localparam int DW          = 8;
  localparam int NSRC        = 4;
  localparam int TW          = 2;
  localparam int MAX_PER_SRC = 2;

  localparam int DEPTH_LOG2 = $clog2(DEPTH);
  localparam int CNT_W      = DEPTH_LOG2 + 1;
  localparam int SRC_CNT_W  = $clog2(MAX_PER_SRC) + 1;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] bits;
  } entry_t;

endpackage

// File: rtl/tagged_arb_queue_if.sv
// Enqueue/dequeue handshake bundle plus occupancy status of the tagged queue.
interface tagged_arb_queue_if;
  import tagged_arb_pkg::*;

  logic                  io_enq_ready;
  logic                  io_enq_valid;
  logic [DW-1:0]         io_enq_bits;
  logic [TW-1:0]         io_enq_tag;
  logic                  io_deq_ready;
  logic                  io_deq_valid;
  logic [DW-1:0]         io_deq_bits;
  logic [TW-1:0]         io_deq_tag;
  logic [CNT_W-1:0]      io_count;
  logic [NSRC-1:0]       io_src_block;

  modport slave (
    input  io_enq_valid, io_enq_bits, io_enq_tag, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits, io_deq_tag,
           io_count, io_src_block
  );

  modport master (
    output io_enq_valid, io_enq_bits, io_enq_tag, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits, io_deq_tag,
           io_count, io_src_block
  );

endinterface

// File: rtl/tagged_arb_queue_src_occupancy_tracker.sv
// Per-source resident-entry counters; a source is blocked once it holds MAX_PER_SRC entries.
module src_occupancy_tracker
  import tagged_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_enq_fire,
  input  logic [TW-1:0]   i_enq_tag,
  input  logic            i_deq_fire,
  input  logic [TW-1:0]   i_deq_tag,
  output logic [NSRC-1:0] o_src_block
);

  localparam logic [SRC_CNT_W-1:0] CNT_MAX  = SRC_CNT_W'(MAX_PER_SRC);
  localparam logic [SRC_CNT_W-1:0] CNT_ZERO = {SRC_CNT_W{1'b0}};
  localparam logic [SRC_CNT_W-1:0] CNT_ONE  = SRC_CNT_W'(1);

  logic [SRC_CNT_W-1:0] r_cnt     [NSRC];
  logic [SRC_CNT_W-1:0] w_cnt_nxt [NSRC];
  logic [NSRC-1:0]      w_inc;
  logic [NSRC-1:0]      w_dec;
  logic [NSRC-1:0]      r_block;

  // Next count per source; same-tag enq+deq cancels, and counters saturate at both ends.
  always_comb begin
    w_inc = {NSRC{1'b0}};
    w_dec = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_inc[i]     = i_enq_fire && (i_enq_tag == TW'(i));
      w_dec[i]     = i_deq_fire && (i_deq_tag == TW'(i));
      if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CNT_MAX)) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != CNT_ZERO)) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Counter and block-bit registers; block mirrors the registered count reaching the cap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSRC; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_block <= {NSRC{1'b0}};
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_block[i] <= (w_cnt_nxt[i] == CNT_MAX);
      end
    end
  end

  assign o_src_block = r_block;

endmodule

// File: rtl/tagged_arb_queue.sv
// FIFO buffering the arbiter's granted beats together with the chosen-source tag.
module tagged_arb_queue
  import tagged_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  tagged_arb_queue_if.slave   q
);

  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  entry_t                r_ram [DEPTH];
  logic [DEPTH_LOG2-1:0] r_enq_ptr;
  logic [DEPTH_LOG2-1:0] r_deq_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_enq_ready;
  logic                  r_deq_valid;

  logic                  w_enq_fire;
  logic                  w_deq_fire;
  logic [CNT_W-1:0]      w_count_nxt;
  entry_t                w_head;
  entry_t                w_wr_entry;

  // Handshakes use only registered ready/valid, so deq_ready never reaches enq_ready.
  always_comb begin
    w_enq_fire       = q.io_enq_valid & r_enq_ready;
    w_deq_fire       = r_deq_valid & q.io_deq_ready;
    w_head           = r_ram[r_deq_ptr];
    w_wr_entry.tag   = q.io_enq_tag;
    w_wr_entry.bits  = q.io_enq_bits;
    w_count_nxt      = r_count;
    case ({w_enq_fire, w_deq_fire})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and the registered ready/valid flags derived from next occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enq_ptr   <= {DEPTH_LOG2{1'b0}};
      r_deq_ptr   <= {DEPTH_LOG2{1'b0}};
      r_count     <= CNT_ZERO;
      r_enq_ready <= 1'b1;
      r_deq_valid <= 1'b0;
    end else begin
      if (w_enq_fire) begin
        r_enq_ptr <= r_enq_ptr + PTR_ONE;
      end
      if (w_deq_fire) begin
        r_deq_ptr <= r_deq_ptr + PTR_ONE;
      end
      r_count     <= w_count_nxt;
      r_enq_ready <= (w_count_nxt != CNT_FULL);
      r_deq_valid <= (w_count_nxt != CNT_ZERO);
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && w_enq_fire) begin
      r_ram[r_enq_ptr] <= w_wr_entry;
    end
  end

  src_occupancy_tracker u_src_occ (
    .clk         (clk),
    .reset       (reset),
    .i_enq_fire  (w_enq_fire),
    .i_enq_tag   (q.io_enq_tag),
    .i_deq_fire  (w_deq_fire),
    .i_deq_tag   (w_head.tag),
    .o_src_block (q.io_src_block)
  );

  assign q.io_enq_ready = r_enq_ready;
  assign q.io_deq_valid = r_deq_valid;
  assign q.io_deq_bits  = w_head.bits;
  assign q.io_deq_tag   = w_head.tag;
  assign q.io_count     = r_count;

endmodule

// File: doc/tagged_arb_queue.md
Name: tagged_arb_queue

Overview:
- Buffering stage directly downstream of the 4-input round-robin arbiter.
- Captures each granted beat (8-bit payload plus 2-bit chosen-source tag) into a small FIFO and presents it on a decoupled dequeue port.
- Tracks per-source occupancy and drives per-source block signals. The parent gates the arbiter's input valids with these, so no single source can monopolise the queue.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- DW, 8, payload width
- NSRC, 4, number of arbiter sources
- TW, 2, tag width, log2(NSRC)
- MAX_PER_SRC, 2, max resident entries per source; 1..DEPTH

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset (state cleared on a rising clk edge while reset==0)
- io_enq_ready  out  1  queue can accept a beat
- io_enq_valid  in  1  arbiter io_out_valid
- io_enq_bits  in  DW  arbiter io_out_bits
- io_enq_tag  in  TW  arbiter io_chosen
- io_deq_ready  in  1  consumer ready
- io_deq_valid  out  1  head entry valid
- io_deq_bits  out  DW  head payload
- io_deq_tag  out  TW  head source tag
- io_count  out  log2(DEPTH)+1  total occupancy
- io_src_block  out  NSRC  bit i = source i at MAX_PER_SRC

Behaviour:
- State:
  - data/tag RAM[DEPTH]
  - enq_ptr, deq_ptr: log2(DEPTH) bits, natural wrap
  - count: log2(DEPTH)+1 bits
  - src_cnt[NSRC]: log2(MAX_PER_SRC)+1 bits each
- Reset (reset==0 at an edge): pointers, count and all src_cnt go to 0. Consequently io_deq_valid=0, io_count=0, io_src_block=0, io_enq_ready=1. RAM contents are not reset.
- Reset mid-operation: all resident entries are discarded. Reset has priority over any simultaneous enq/deq.
- io_enq_ready = (count != DEPTH). Depends only on registered state, with no combinational path from io_deq_ready.
- enq_fire = io_enq_valid & io_enq_ready. On fire:
  - RAM[enq_ptr] <= {bits, tag}
  - enq_ptr++
  - src_cnt[tag]++
- io_deq_valid = (count != 0).
- io_deq_bits and io_deq_tag = RAM[deq_ptr], combinational read of registered state.
- deq_fire = io_deq_valid & io_deq_ready. On fire:
  - deq_ptr++
  - src_cnt[head tag]--
- count update: +1 on enq_fire only, -1 on deq_fire only, unchanged on both or neither.
- Simultaneous enq_fire and deq_fire:
  - If the tags match, that src_cnt is unchanged.
  - If the tags differ, one counter increments and the other decrements.
- Latency and flow:
  - Enqueue-to-dequeue-visible latency is 1 cycle; there is no flow-through when empty.
  - When full, enqueue is refused even if io_deq_ready=1 in the same cycle; there is no pass-through.
- io_src_block[i] = (src_cnt[i] == MAX_PER_SRC), registered-state derived.
- The queue does not itself reject a tag whose block bit is set. The parent must mask that arbiter input valid with ~io_src_block[i].
  - Enqueuing a blocked tag is a protocol violation. The bench asserts it never occurs.
  - The implementation saturates src_cnt rather than wrapping.
- Invariants (bench assertions):
  - sum(src_cnt) == count
  - count <= DEPTH
  - no deq_fire when count==0
- Pointer wrap: at DEPTH-1, the next increment goes to 0.

Decomposition:
- Shared package tagged_arb_pkg holds:
  - the entry struct {tag[TW], bits[DW]}
  - the constants DEPTH_LOG2 and SRC_CNT_W
- One natural sub-module, src_occupancy_tracker:
  - contains the NSRC counters and the block-bit generation
  - inputs: enq_fire, enq_tag, deq_fire, deq_tag
  - outputs: src_block
- The FIFO storage and pointers stay in the top level.

Test Plan:
- Reset: drive reset=0 for 2 cycles with io_enq_valid=1 -> io_deq_valid=0, io_count=0, io_enq_ready=1, io_src_block=4'b0000. No entry is accepted during reset.
- Single beat: enq bits=0xA5, tag=2 with io_deq_ready=0 -> next cycle io_deq_valid=1, bits=0xA5, tag=2, io_count=1.
- Per-source cap: enq tag=1 twice (0x11, 0x12) -> io_src_block=4'b0010, io_count=2. Dequeue one -> io_src_block=4'b0000, head=0x12.
- Fill and full: enq tags 0,1,2,3 (0x00..0x03) with io_deq_ready=0 -> io_count=4, io_enq_ready=0. Assert io_deq_ready=1 with enq_valid=1 -> a 5th beat is accepted only on the following cycle. Order is preserved, with pointers wrapping.
- Simultaneous same-tag: count=1 (tag 3), enq tag 3 and deq in the same cycle -> io_count stays 1, src_cnt[3] stays 1, io_src_block=0.
- Reset mid-stream: 3 entries resident, pulse reset=0 for one cycle while enq and deq fire -> all counts 0, io_deq_valid=0 next cycle, stale data never appears on dequeue.
